// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and encodings for the pipeline hazard controller: forwarding
// selects, controller FSM states and the per-stage shadow destination tag.
package pipeline_pkg;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;
    localparam logic [4:0] REG_X0  = 5'd0;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } pipe_state_e;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       wr_en;
        logic       is_load;
    } shadow_tag_t;

    // A producer only matters if it really writes a non-x0 register the consumer reads.
    function automatic logic tag_match(shadow_tag_t tag, logic [4:0] rs, logic uses);
        return tag.valid & tag.wr_en & (tag.rd != REG_X0) & uses & (tag.rd == rs);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_scoreboard.sv
// Shadow destination tags for EX/MEM/WB and the ID-source match logic against
// the EX and MEM producers.
module hazard_scoreboard
    import pipeline_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        advance_i,
    input  logic        ex_load_i,
    input  logic [4:0]  id_rs1_i,
    input  logic [4:0]  id_rs2_i,
    input  logic        id_uses_rs1_i,
    input  logic        id_uses_rs2_i,
    input  logic [4:0]  id_rd_i,
    input  logic        id_rf_wr_en_i,
    input  logic        id_is_load_i,
    output shadow_tag_t ex_tag_o,
    output shadow_tag_t mem_tag_o,
    output shadow_tag_t wb_tag_o,
    output logic        ex_hit_rs1_o,
    output logic        ex_hit_rs2_o,
    output logic        mem_hit_rs1_o,
    output logic        mem_hit_rs2_o
);

    shadow_tag_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;

    always_comb begin
        ex_d  = ex_q;
        mem_d = mem_q;
        wb_d  = wb_q;
        if (advance_i) begin
            wb_d  = mem_q;
            mem_d = ex_q;
            ex_d  = '0;
            if (ex_load_i) begin
                ex_d.valid   = 1'b1;
                ex_d.rd      = id_rd_i;
                ex_d.wr_en   = id_rf_wr_en_i;
                ex_d.is_load = id_is_load_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    assign ex_hit_rs1_o  = tag_match(ex_q,  id_rs1_i, id_uses_rs1_i);
    assign ex_hit_rs2_o  = tag_match(ex_q,  id_rs2_i, id_uses_rs2_i);
    assign mem_hit_rs1_o = tag_match(mem_q, id_rs1_i, id_uses_rs1_i);
    assign mem_hit_rs2_o = tag_match(mem_q, id_rs2_i, id_uses_rs2_i);

    assign ex_tag_o  = ex_q;
    assign mem_tag_o = mem_q;
    assign wb_tag_o  = wb_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forwarding controller for the 5-stage pipeline: memory-busy freeze
// FSM with timeout, branch flush, load-use stall, registered forwarding selects.
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             id_valid_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             id_uses_rs1_i,
    input  logic             id_uses_rs2_i,
    input  logic [4:0]       id_rd_i,
    input  logic             id_rf_wr_en_i,
    input  logic             id_is_load_i,
    input  logic             ex_branch_taken_i,
    input  logic             mem_req_i,
    input  logic             mem_ready_i,
    output logic             stall_if_o,
    output logic             stall_id_o,
    output logic             bubble_ex_o,
    output logic             flush_if_o,
    output logic             flush_id_o,
    output logic             freeze_o,
    output logic [1:0]       fwd_a_sel_o,
    output logic [1:0]       fwd_b_sel_o,
    output logic             mem_err_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic [CNT_W-1:0] freeze_cnt_o,
    output pipe_state_e      state_o,
    output shadow_tag_t      ex_tag_o,
    output shadow_tag_t      mem_tag_o,
    output shadow_tag_t      wb_tag_o
);

    localparam int TO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    pipe_state_e      state_q, state_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic [1:0]       fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, freeze_cnt_q;
    logic             timing_out, load_use, kill_ex;
    logic             ex_hit_rs1, ex_hit_rs2, mem_hit_rs1, mem_hit_rs2;

    hazard_scoreboard u_scoreboard (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .advance_i     (!freeze_o),
        .ex_load_i     (id_valid_i & !kill_ex),
        .id_rs1_i      (id_rs1_i),
        .id_rs2_i      (id_rs2_i),
        .id_uses_rs1_i (id_uses_rs1_i),
        .id_uses_rs2_i (id_uses_rs2_i),
        .id_rd_i       (id_rd_i),
        .id_rf_wr_en_i (id_rf_wr_en_i),
        .id_is_load_i  (id_is_load_i),
        .ex_tag_o      (ex_tag_o),
        .mem_tag_o     (mem_tag_o),
        .wb_tag_o      (wb_tag_o),
        .ex_hit_rs1_o  (ex_hit_rs1),
        .ex_hit_rs2_o  (ex_hit_rs2),
        .mem_hit_rs1_o (mem_hit_rs1),
        .mem_hit_rs2_o (mem_hit_rs2)
    );

    // Freeze is combinational so the very first busy cycle already holds the pipe.
    always_comb begin
        state_d    = state_q;
        to_cnt_d   = '0;
        timing_out = 1'b0;
        freeze_o   = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (mem_req_i && !mem_ready_i) begin
                    freeze_o = 1'b1;
                    state_d  = ST_MEM_WAIT;
                end
            end
            ST_MEM_WAIT: begin
                timing_out = !mem_ready_i && (to_cnt_q == TO_W'(MEM_TIMEOUT - 1));
                if (mem_ready_i || timing_out) begin
                    state_d = ST_RUN;
                end else begin
                    freeze_o = 1'b1;
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    assign mem_err_o = timing_out & !reset_i;
    assign load_use  = ex_tag_o.is_load & (ex_hit_rs1 | ex_hit_rs2);
    assign kill_ex   = bubble_ex_o | flush_id_o;

    always_comb begin
        stall_if_o  = 1'b0;
        stall_id_o  = 1'b0;
        bubble_ex_o = 1'b0;
        flush_if_o  = 1'b0;
        flush_id_o  = 1'b0;
        if (freeze_o) begin
            stall_if_o = 1'b1;
            stall_id_o = 1'b1;
        end else if (ex_branch_taken_i) begin
            flush_if_o = 1'b1;
            flush_id_o = 1'b1;
        end else if (load_use) begin
            stall_if_o  = 1'b1;
            stall_id_o  = 1'b1;
            bubble_ex_o = 1'b1;
        end
    end

    // An ALU result in EX beats an older one in MEM; a load in EX cannot forward yet.
    always_comb begin
        fwd_a_d = FWD_REG;
        fwd_b_d = FWD_REG;
        if (!kill_ex) begin
            if (ex_hit_rs1 && !ex_tag_o.is_load) fwd_a_d = FWD_MEM;
            else if (mem_hit_rs1)                fwd_a_d = FWD_WB;
            if (ex_hit_rs2 && !ex_tag_o.is_load) fwd_b_d = FWD_MEM;
            else if (mem_hit_rs2)                fwd_b_d = FWD_WB;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= ST_RUN;
            to_cnt_q     <= '0;
            fwd_a_q      <= FWD_REG;
            fwd_b_q      <= FWD_REG;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            freeze_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            to_cnt_q <= to_cnt_d;
            if (!freeze_o) begin
                fwd_a_q <= fwd_a_d;
                fwd_b_q <= fwd_b_d;
            end
            if (bubble_ex_o && stall_cnt_q != CNT_MAX)  stall_cnt_q  <= stall_cnt_q + 1'b1;
            if (flush_id_o && flush_cnt_q != CNT_MAX)   flush_cnt_q  <= flush_cnt_q + 1'b1;
            if (freeze_o && freeze_cnt_q != CNT_MAX)    freeze_cnt_q <= freeze_cnt_q + 1'b1;
        end
    end

    assign fwd_a_sel_o  = fwd_a_q;
    assign fwd_b_sel_o  = fwd_b_q;
    assign stall_cnt_o  = stall_cnt_q;
    assign flush_cnt_o  = flush_cnt_q;
    assign freeze_cnt_o = freeze_cnt_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios plus a randomized run
// checked against an instruction-level model of the pipeline.
module tb_pipeline_hazard_ctrl;
    import pipeline_pkg::*;

    localparam int MT = 16;
    localparam int CW = 5;
    localparam int CNT_SAT = (1 << CW) - 1;

    logic clk = 1'b0, reset = 1'b0;
    logic id_valid, id_uses_rs1, id_uses_rs2, id_rf_wr_en, id_is_load;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic ex_branch_taken, mem_req, mem_ready;
    logic stall_if, stall_id, bubble_ex, flush_if, flush_id, freeze, mem_err;
    logic [1:0] fwd_a_sel, fwd_b_sel;
    logic [CW-1:0] stall_cnt, flush_cnt, freeze_cnt;
    pipe_state_e state;
    shadow_tag_t ex_tag, mem_tag, wb_tag;
    logic [6:0] ctl;

    assign ctl = {stall_if, stall_id, bubble_ex, flush_if, flush_id, freeze, mem_err};

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
        .clk_i(clk), .reset_i(reset),
        .id_valid_i(id_valid), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
        .id_uses_rs1_i(id_uses_rs1), .id_uses_rs2_i(id_uses_rs2),
        .id_rd_i(id_rd), .id_rf_wr_en_i(id_rf_wr_en), .id_is_load_i(id_is_load),
        .ex_branch_taken_i(ex_branch_taken), .mem_req_i(mem_req), .mem_ready_i(mem_ready),
        .stall_if_o(stall_if), .stall_id_o(stall_id), .bubble_ex_o(bubble_ex),
        .flush_if_o(flush_if), .flush_id_o(flush_id), .freeze_o(freeze),
        .fwd_a_sel_o(fwd_a_sel), .fwd_b_sel_o(fwd_b_sel), .mem_err_o(mem_err),
        .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt), .freeze_cnt_o(freeze_cnt),
        .state_o(state), .ex_tag_o(ex_tag), .mem_tag_o(mem_tag), .wb_tag_o(wb_tag)
    );

    // clock / reset
    always #5 clk = ~clk;

    // reference model: instructions occupying EX/MEM/WB, wait bookkeeping, counters
    typedef struct { bit valid; int rd; bit wr; bit ld; } instr_t;
    instr_t m_ex, m_mem, m_wb;
    bit m_wait;
    int m_wait_n, m_fwd_a, m_fwd_b, m_stall_cnt, m_flush_cnt, m_freeze_cnt;
    bit e_freeze, e_err, e_flush, e_stall;
    logic [3:0] exp_q[$];
    int n_cmp = 0, n_err = 0;

    function automatic bit produces(instr_t p, int rs, bit uses);
        return uses && p.valid && p.wr && p.rd != 0 && p.rd == rs;
    endfunction

    function automatic int pick_fwd(instr_t ex, instr_t mem, int rs, bit uses);
        if (produces(ex, rs, uses) && !ex.ld) return 1;
        if (produces(mem, rs, uses)) return 2;
        return 0;
    endfunction

    function automatic int sat_inc(int v);
        return (v >= CNT_SAT) ? CNT_SAT : v + 1;
    endfunction

    task automatic model_eval();
        bit busy, tmo;
        busy = m_wait ? !mem_ready : (mem_req && !mem_ready);
        tmo = m_wait && !mem_ready && (m_wait_n == MT - 1);
        e_freeze = busy && !tmo;
        e_err = tmo && !reset;
        e_flush = !e_freeze && ex_branch_taken;
        e_stall = !e_freeze && !ex_branch_taken && m_ex.ld &&
                  (produces(m_ex, id_rs1, id_uses_rs1) || produces(m_ex, id_rs2, id_uses_rs2));
    endtask

    task automatic model_edge();
        instr_t none;
        none = '{valid: 0, rd: 0, wr: 0, ld: 0};
        if (reset) begin
            m_ex = none; m_mem = none; m_wb = none;
            m_wait = 0; m_wait_n = 0; m_fwd_a = 0; m_fwd_b = 0;
            m_stall_cnt = 0; m_flush_cnt = 0; m_freeze_cnt = 0;
            return;
        end
        if (e_stall) m_stall_cnt = sat_inc(m_stall_cnt);
        if (e_flush) m_flush_cnt = sat_inc(m_flush_cnt);
        if (e_freeze) m_freeze_cnt = sat_inc(m_freeze_cnt);
        if (!m_wait) begin
            m_wait = mem_req && !mem_ready;
            m_wait_n = 0;
        end else if (mem_ready || m_wait_n == MT - 1) begin
            m_wait = 0;
            m_wait_n = 0;
        end else begin
            m_wait_n++;
        end
        if (!e_freeze) begin
            if (e_flush || e_stall) begin
                m_fwd_a = 0; m_fwd_b = 0;
            end else begin
                m_fwd_a = pick_fwd(m_ex, m_mem, id_rs1, id_uses_rs1);
                m_fwd_b = pick_fwd(m_ex, m_mem, id_rs2, id_uses_rs2);
            end
            m_wb = m_mem;
            m_mem = m_ex;
            if (id_valid && !e_flush && !e_stall)
                m_ex = '{valid: 1, rd: int'(id_rd), wr: id_rf_wr_en, ld: id_is_load};
            else
                m_ex = none;
        end
    endtask

    // driver tasks: inputs change just after the falling edge
    task automatic tick();
        model_eval();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic drive_id(input bit v, input int rs1, input int rs2, input bit u1, input bit u2,
                            input int rd, input bit wr, input bit ld);
        id_valid = v; id_rs1 = 5'(rs1); id_rs2 = 5'(rs2); id_uses_rs1 = u1; id_uses_rs2 = u2;
        id_rd = 5'(rd); id_rf_wr_en = wr; id_is_load = ld;
    endtask

    task automatic idle_inputs();
        drive_id(0, 0, 0, 0, 0, 0, 0, 0);
        ex_branch_taken = 0; mem_req = 0; mem_ready = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        tick();
        reset = 0;
    endtask

    // drives an unanswered memory request until the freeze drops (bounded)
    task automatic run_timeout(output int nf, output int ne, output int err_at, output bit done);
        nf = 0; ne = 0; err_at = -1; done = 0;
        mem_req = 1; mem_ready = 0;
        for (int c = 0; c < 3 * MT; c++) begin
            #1;
            if (freeze) nf++;
            if (mem_err) begin ne++; err_at = c; end
            if (!freeze) begin
                done = 1;
                tick();
                mem_req = 0;
                break;
            end
            tick();
        end
        mem_req = 0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_cmp++; if (ctl !== 7'b0) begin n_err++; $display("FAIL reset_ctl got=%b want=%b", ctl, 7'b0); end
        n_cmp++; if ({fwd_a_sel, fwd_b_sel} !== 4'b0) begin n_err++; $display("FAIL reset_fwd got=%b want=0000", {fwd_a_sel, fwd_b_sel}); end
        n_cmp++; if ({stall_cnt, flush_cnt, freeze_cnt} !== '0) begin n_err++; $display("FAIL reset_cnt got=%0d/%0d/%0d want=0/0/0", stall_cnt, flush_cnt, freeze_cnt); end
        n_cmp++; if (state !== ST_RUN) begin n_err++; $display("FAIL reset_state got=%0d want=%0d", state, ST_RUN); end
        n_cmp++; if ({ex_tag.valid, mem_tag.valid, wb_tag.valid} !== 3'b0) begin n_err++; $display("FAIL reset_tags got=%b want=000", {ex_tag.valid, mem_tag.valid, wb_tag.valid}); end
    endtask

    task automatic test_load_use();
        do_reset();
        drive_id(1, 0, 0, 0, 0, 5, 1, 1);
        tick();
        drive_id(1, 5, 1, 1, 1, 6, 1, 0);
        #1;
        n_cmp++; if (ctl !== 7'b1110000) begin n_err++; $display("FAIL load_use_stall got=%b want=%b", ctl, 7'b1110000); end
        tick();
        #1;
        n_cmp++; if (ctl !== 7'b0) begin n_err++; $display("FAIL load_use_release got=%b want=%b", ctl, 7'b0); end
        n_cmp++; if (stall_cnt !== CW'(1)) begin n_err++; $display("FAIL load_use_stall_cnt got=%0d want=1", stall_cnt); end
        tick();
        #1;
        n_cmp++; if (fwd_a_sel !== 2'b10 || fwd_b_sel !== 2'b00) begin n_err++; $display("FAIL load_use_fwd got=%b/%b want=10/00", fwd_a_sel, fwd_b_sel); end
    endtask

    task automatic test_alu_fwd();
        do_reset();
        drive_id(1, 0, 0, 0, 0, 5, 1, 0);
        tick();
        drive_id(1, 5, 5, 1, 1, 7, 1, 0);
        #1;
        n_cmp++; if (ctl !== 7'b0) begin n_err++; $display("FAIL alu_no_stall got=%b want=%b", ctl, 7'b0); end
        tick();
        #1;
        n_cmp++; if (fwd_a_sel !== 2'b01 || fwd_b_sel !== 2'b01) begin n_err++; $display("FAIL alu_fwd got=%b/%b want=01/01", fwd_a_sel, fwd_b_sel); end
    endtask

    task automatic test_x0();
        do_reset();
        drive_id(1, 0, 0, 0, 0, 0, 1, 1);
        tick();
        drive_id(1, 0, 0, 1, 1, 3, 1, 0);
        #1;
        n_cmp++; if (ctl !== 7'b0) begin n_err++; $display("FAIL x0_no_stall got=%b want=%b", ctl, 7'b0); end
        tick();
        #1;
        n_cmp++; if ({fwd_a_sel, fwd_b_sel} !== 4'b0) begin n_err++; $display("FAIL x0_fwd got=%b want=0000", {fwd_a_sel, fwd_b_sel}); end
    endtask

    task automatic test_branch_over_load_use();
        do_reset();
        drive_id(1, 0, 0, 0, 0, 5, 1, 1);
        tick();
        drive_id(1, 5, 1, 1, 1, 6, 1, 0);
        ex_branch_taken = 1;
        #1;
        n_cmp++; if (ctl !== 7'b0001100) begin n_err++; $display("FAIL branch_flush got=%b want=%b", ctl, 7'b0001100); end
        tick();
        ex_branch_taken = 0;
        idle_inputs();
        #1;
        n_cmp++; if (flush_cnt !== CW'(1) || stall_cnt !== CW'(0)) begin n_err++; $display("FAIL branch_counts got=%0d/%0d want=1/0", flush_cnt, stall_cnt); end
        n_cmp++; if (ex_tag.valid !== 1'b0) begin n_err++; $display("FAIL branch_ex_squashed got=%b want=0", ex_tag.valid); end
    endtask

    task automatic test_mem_wait();
        shadow_tag_t want;
        want = '{valid: 1'b1, rd: 5'd5, wr_en: 1'b1, is_load: 1'b1};
        do_reset();
        drive_id(1, 0, 0, 0, 0, 5, 1, 1);
        tick();
        drive_id(1, 5, 1, 1, 1, 6, 1, 0);
        mem_req = 1; mem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (ctl !== 7'b1100010) begin n_err++; $display("FAIL mem_wait_freeze%0d got=%b want=%b", i, ctl, 7'b1100010); end
            tick();
        end
        mem_ready = 1;
        #1;
        n_cmp++; if (ctl !== 7'b1110000) begin n_err++; $display("FAIL mem_wait_release got=%b want=%b", ctl, 7'b1110000); end
        n_cmp++; if (freeze_cnt !== CW'(3)) begin n_err++; $display("FAIL mem_wait_freeze_cnt got=%0d want=3", freeze_cnt); end
        n_cmp++; if (ex_tag !== want) begin n_err++; $display("FAIL mem_wait_ex_tag got=%h want=%h", ex_tag, want); end
        tick();
        idle_inputs();
    endtask

    task automatic test_mem_timeout();
        int nf, ne, at;
        bit done;
        do_reset();
        run_timeout(nf, ne, at, done);
        n_cmp++; if (!done || nf != MT || ne != 1 || at != MT) begin n_err++; $display("FAIL timeout_1 got=done%0d freeze%0d err%0d at%0d want=done1 freeze%0d err1 at%0d", done, nf, ne, at, MT, MT); end
        #1;
        n_cmp++; if (state !== ST_RUN || mem_err !== 1'b0) begin n_err++; $display("FAIL timeout_after got=state%0d err%b want=state0 err0", state, mem_err); end
        n_cmp++; if (freeze_cnt !== CW'(MT)) begin n_err++; $display("FAIL timeout_freeze_cnt got=%0d want=%0d", freeze_cnt, MT); end
        run_timeout(nf, ne, at, done);
        #1;
        n_cmp++; if (!done || ne != 1) begin n_err++; $display("FAIL timeout_2 got=done%0d err%0d want=done1 err1", done, ne); end
        n_cmp++; if (freeze_cnt !== CW'(CNT_SAT)) begin n_err++; $display("FAIL freeze_cnt_saturate got=%0d want=%0d", freeze_cnt, CNT_SAT); end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        mem_req = 1; mem_ready = 0;
        for (int i = 0; i < MT; i++) tick();
        reset = 1;
        #1;
        n_cmp++; if (mem_err !== 1'b0) begin n_err++; $display("FAIL reset_at_timeout_err got=%b want=0", mem_err); end
        tick();
        reset = 0;
        idle_inputs();
        #1;
        n_cmp++; if (ctl !== 7'b0 || state !== ST_RUN) begin n_err++; $display("FAIL reset_mid_wait got=ctl%b state%0d want=ctl0000000 state0", ctl, state); end
        n_cmp++; if ({stall_cnt, flush_cnt, freeze_cnt} !== '0) begin n_err++; $display("FAIL reset_mid_wait_cnt got=%0d/%0d/%0d want=0/0/0", stall_cnt, flush_cnt, freeze_cnt); end
    endtask

    task automatic test_random();
        logic [6:0] e_ctl;
        logic [3:0] e_fwd;
        int ready_pct;
        do_reset();
        exp_q.delete();
        exp_q.push_back(4'b0);
        for (int c = 0; c < 600; c++) begin
            ready_pct = (c < 300) ? 60 : 5;
            reset = ($urandom_range(0, 99) < 1);
            drive_id($urandom_range(0, 9) < 8, $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3),
                     $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 3);
            ex_branch_taken = ($urandom_range(0, 9) < 1);
            mem_req = ($urandom_range(0, 3) == 0);
            mem_ready = ($urandom_range(0, 99) < ready_pct);
            #1;
            model_eval();
            e_ctl = {e_stall | e_freeze, e_stall | e_freeze, e_stall, e_flush, e_flush, e_freeze, e_err};
            n_cmp++; if (ctl !== e_ctl) begin n_err++; $display("FAIL rand_ctl c=%0d got=%b want=%b", c, ctl, e_ctl); end
            e_fwd = exp_q.pop_front();
            n_cmp++; if ({fwd_a_sel, fwd_b_sel} !== e_fwd) begin n_err++; $display("FAIL rand_fwd c=%0d got=%b want=%b", c, {fwd_a_sel, fwd_b_sel}, e_fwd); end
            n_cmp++; if (stall_cnt !== CW'(m_stall_cnt) || flush_cnt !== CW'(m_flush_cnt) || freeze_cnt !== CW'(m_freeze_cnt)) begin
                n_err++; $display("FAIL rand_cnt c=%0d got=%0d/%0d/%0d want=%0d/%0d/%0d", c, stall_cnt, flush_cnt, freeze_cnt, m_stall_cnt, m_flush_cnt, m_freeze_cnt);
            end
            tick();
            exp_q.push_back({2'(m_fwd_a), 2'(m_fwd_b)});
        end
        reset = 0;
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_load_use();
        test_alu_fwd();
        test_x0();
        test_branch_over_load_use();
        test_mem_wait();
        test_mem_timeout();
        test_reset_mid_wait();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
